// File: rtl/alu_nibble_sequencer_pkg.sv
// alu_nibble_sequencer_pkg
//   Types and constants shared by the nibble sequencer, its interface and
//   the bench: the sequencer state encoding and the ALU slice width.
package alu_nibble_sequencer_pkg;

  // Width of one 74181 slice
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : alu_nibble_sequencer_pkg

// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if
//   Bundles the request/result signals and the 74181 slice connection of the
//   nibble sequencer.
//   Request side : start, a_in, b_in, s_in, m_in, cn_in
//   Result side  : busy, done, result, cout, equal
//   Slice drive  : alu_a, alu_b, alu_s, alu_m, alu_cn
//   Slice return : alu_f, alu_cn4, alu_equal (combinational from the 74181)
//   modport slave  : the sequencer
//   modport master : the integration side (requester plus the external 74181)
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  import alu_nibble_sequencer_pkg::*;

  localparam int W = NIB_W * NIBBLES;

  logic             start;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic [3:0]       s_in;
  logic             m_in;
  logic             cn_in;

  logic             busy;
  logic             done;
  logic [W-1:0]     result;
  logic             cout;
  logic             equal;

  logic [NIB_W-1:0] alu_a;
  logic [NIB_W-1:0] alu_b;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_cn;
  logic [NIB_W-1:0] alu_f;
  logic             alu_cn4;
  logic             alu_equal;

  modport slave (
    input  start, a_in, b_in, s_in, m_in, cn_in,
    input  alu_f, alu_cn4, alu_equal,
    output busy, done, result, cout, equal,
    output alu_a, alu_b, alu_s, alu_m, alu_cn
  );

  modport master (
    output start, a_in, b_in, s_in, m_in, cn_in,
    output alu_f, alu_cn4, alu_equal,
    input  busy, done, result, cout, equal,
    input  alu_a, alu_b, alu_s, alu_m, alu_cn
  );

endinterface : alu_nibble_sequencer_if

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Runs a W-bit operation (W = 4*NIBBLES) through a single external 74181
//   slice, one nibble per clock, least significant nibble first, chaining the
//   slice carry through a register.
//   Ports:
//     clk : clock, all state on the rising edge
//     rst : asynchronous active-high reset
//     bus : alu_nibble_sequencer_if.slave (request, result and slice signals)
//   A start accepted on edge N gives done=1 in the cycle after edge N+NIBBLES.
//   result/cout/equal hold from DONE until the next accepted start.
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave bus
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [W-1:0]     a_lat;
  logic [W-1:0]     b_lat;
  logic             eq_acc;

  assign next_idx = idx + IDX_W'(1);

  // alu_cn doubles as the chained carry register. alu_a/alu_b are preloaded
  // one cycle ahead so the slice sees nibble idx throughout each RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      eq_acc     <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.equal  <= 1'b0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_s  <= '0;
      bus.alu_m  <= 1'b0;
      bus.alu_cn <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_lat      <= bus.a_in;
            b_lat      <= bus.b_in;
            bus.alu_s  <= bus.s_in;
            bus.alu_m  <= bus.m_in;
            bus.alu_cn <= bus.cn_in;
            bus.alu_a  <= bus.a_in[NIB_W-1:0];
            bus.alu_b  <= bus.b_in[NIB_W-1:0];
            idx        <= '0;
            eq_acc     <= 1'b1;
            bus.busy   <= 1'b1;
            state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          bus.result[idx*NIB_W +: NIB_W] <= bus.alu_f;
          bus.alu_cn <= bus.alu_cn4;
          eq_acc     <= eq_acc & bus.alu_equal;
          if (idx == LAST_IDX) begin
            bus.cout  <= bus.alu_cn4;
            bus.equal <= eq_acc & bus.alu_equal;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx       <= next_idx;
            bus.alu_a <= a_lat[next_idx*NIB_W +: NIB_W];
            bus.alu_b <= b_lat[next_idx*NIB_W +: NIB_W];
          end
        end

        ST_DONE: begin
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : alu_nibble_sequencer

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer
//   Directed bench for alu_nibble_sequencer (NIBBLES=4) with a behavioural
//   74181 slice (active-high data) hooked to the alu_* signals.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = NIB_W * NIBBLES;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74181 slice, active-high data. x/y are the per-bit internal terms;
  // propagate = ~x, generate = ~y, internal carry c is active-high.
  logic [3:0] x_t, y_t;
  logic [4:0] c_t;

  always_comb begin
    x_t = ~(bus.alu_a | (bus.alu_b & {4{bus.alu_s[0]}}) | (~bus.alu_b & {4{bus.alu_s[1]}}));
    y_t = ~((bus.alu_a & ~bus.alu_b & {4{bus.alu_s[2]}}) | (bus.alu_a & bus.alu_b & {4{bus.alu_s[3]}}));
    c_t[0] = ~bus.alu_cn;
    c_t[1] = ~y_t[0] | (~x_t[0] & c_t[0]);
    c_t[2] = ~y_t[1] | (~x_t[1] & c_t[1]);
    c_t[3] = ~y_t[2] | (~x_t[2] & c_t[2]);
    c_t[4] = ~y_t[3] | (~x_t[3] & c_t[3]);
    bus.alu_f     = bus.alu_m ? ~(x_t ^ y_t) : (x_t ^ y_t ^ c_t[3:0]);
    bus.alu_cn4   = ~c_t[4];
    bus.alu_equal = &bus.alu_f;
  end

  // Launch one operation from IDLE and wait for done (bounded).
  // lat = edges after the start edge until done is seen (99 on timeout).
  // inject=1 pulses start with other operands during the second RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cn,
                        input logic inject,
                        output int lat, output logic [W-1:0] res,
                        output logic co, output logic eq, output logic busy_seen);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.s_in  = s;
    bus.m_in  = m;
    bus.cn_in = cn;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_in  = 16'hDEAD;
    bus.b_in  = 16'hBEEF;
    bus.s_in  = 4'b0000;
    bus.m_in  = ~m;
    bus.cn_in = ~cn;
    busy_seen = bus.busy;
    lat = 99;
    res = '0;
    co  = 1'b0;
    eq  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (inject && k == 2) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        co  = bus.cout;
        eq  = bus.equal;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.cout, bus.equal} !== 4'b0000 || bus.result !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b equal=%b result=%h, required all 0",
               bus.busy, bus.done, bus.cout, bus.equal, bus.result);
    end
    n_cmp++;
    if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_s !== 4'h0 ||
        bus.alu_m !== 1'b0 || bus.alu_cn !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_alu: a=%h b=%h s=%h m=%b cn=%b, required all 0",
               bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_cn);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; logic [W-1:0] res; logic co, eq, bz;
    run_op(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat, res, co, eq, bz);
    n_cmp++;
    if (bz !== 1'b1) begin
      n_bad++;
      $display("FAIL add_busy: busy=%b, required 1", bz);
    end
    n_cmp++;
    if (lat !== NIBBLES) begin
      n_bad++;
      $display("FAIL add_latency: edges after start=%0d, required %0d (99=timeout)", lat, NIBBLES);
    end
    n_cmp++;
    if (res !== 16'h1300 || co !== 1'b1) begin
      n_bad++;
      $display("FAIL add_result: result=%h cout=%b, required 1300 cout=1", res, co);
    end
    n_cmp++;
    if (bus.alu_s !== 4'b1001 || bus.alu_m !== 1'b0) begin
      n_bad++;
      $display("FAIL add_latched_sel: alu_s=%b alu_m=%b, required 1001 0", bus.alu_s, bus.alu_m);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL add_done_pulse: done=%b one cycle later, required 0", bus.done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.result !== 16'h1300 || bus.cout !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL add_hold: result=%h cout=%b busy=%b, required 1300 1 0",
               bus.result, bus.cout, bus.busy);
    end
  endtask

  task automatic test_carry_out();
    int lat; logic [W-1:0] res; logic co, eq, bz;
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, lat, res, co, eq, bz);
    n_cmp++;
    if (lat !== NIBBLES || res !== 16'h0000 || co !== 1'b0) begin
      n_bad++;
      $display("FAIL carry_out: lat=%0d result=%h cout=%b, required lat=4 0000 cout=0", lat, res, co);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_compare();
    int lat; logic [W-1:0] res; logic co, eq, bz;
    run_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 1'b0, lat, res, co, eq, bz);
    n_cmp++;
    if (lat !== NIBBLES || res !== 16'hFFFF || eq !== 1'b1) begin
      n_bad++;
      $display("FAIL cmp_equal: lat=%0d result=%h equal=%b, required lat=4 FFFF 1", lat, res, eq);
    end
    @(posedge clk); #1;
    run_op(16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 1'b0, lat, res, co, eq, bz);
    n_cmp++;
    if (lat !== NIBBLES || res !== 16'hFFFE || eq !== 1'b0 || co !== 1'b1) begin
      n_bad++;
      $display("FAIL cmp_unequal: lat=%0d result=%h equal=%b cout=%b, required lat=4 FFFE 0 1",
               lat, res, eq, co);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] res; logic co, eq, bz;
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1, lat, res, co, eq, bz);
    n_cmp++;
    if (lat !== NIBBLES || res !== 16'h0FF0) begin
      n_bad++;
      $display("FAIL xor_ignore_start: lat=%0d result=%h, required lat=4 0FF0", lat, res);
    end
    // DONE -> IDLE edge, then start in the first IDLE cycle
    @(posedge clk); #1;
    run_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, 1'b0, lat, res, co, eq, bz);
    n_cmp++;
    if (lat !== NIBBLES || res !== 16'h1010 || co !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back: lat=%0d result=%h cout=%b, required lat=4 1010 1", lat, res, co);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_abort();
    int seen_done;
    seen_done = 0;
    bus.a_in  = 16'h1234;
    bus.b_in  = 16'h1111;
    bus.s_in  = 4'b1001;
    bus.m_in  = 1'b0;
    bus.cn_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // now in RUN cycle 1; advance into RUN cycle 3
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.result === 16'h0000) begin
      n_bad++;
      $display("FAIL abort_precond: busy=%b result=%h, required busy=1 nonzero partial", bus.busy, bus.result);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result !== 16'h0000 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_async: busy=%b result=%h done=%b, required 0 0000 0",
               bus.busy, bus.result, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0 || bus.result !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_no_done: done pulses=%0d result=%h, required 0 0000", seen_done, bus.result);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.s_in  = '0;
    bus.m_in  = 1'b0;
    bus.cn_in = 1'b1;
    test_reset();
    test_add();
    test_carry_out();
    test_compare();
    test_back_to_back();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_nibble_sequencer
